// File: rtl/rx_word_packer_pkg.sv
// rx_word_packer_pkg: receive-path types shared by the word packer and the Rx output buffer status logic.
package rx_word_packer_pkg;
   localparam int WORD_W     = 32;
   localparam int BYTE_W     = 8;
   localparam int DESC_LEN_W = 16;
   typedef enum logic [1:0] {IDLE, PACK, FLUSH, DESC} state_e;
   typedef struct packed {
      logic [DESC_LEN_W-1:0] len;
      logic                  ovf;
   } desc_t;
endpackage

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs the decoded byte stream little-endian into 32-bit buffer words and emits one descriptor per frame.
module rx_word_packer
   import rx_word_packer_pkg::*;
#(
   parameter int MAX_FRAME_BYTES = 1024,
   parameter int LEN_W           = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   input  logic              wr_full,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [LEN_W-1:0]  desc_len,
   output logic              desc_ovf,
   output logic              busy
);
   state_e            state_q;
   logic [WORD_W-1:0] sh_q, sh_d, w_q;
   logic [1:0]        lane_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              ovf_q, pend_q, acc, keep;

   always_comb begin
      sh_d = sh_q;
      sh_d[{lane_q, 3'b000} +: BYTE_W] = s_data;
   end

   // A finished word parks in w_q so the next frame bytes can keep flowing into sh_q.
   assign s_ready    = !ARESET && (state_q == IDLE || (state_q == PACK && !(pend_q && wr_full)));
   assign acc        = s_valid && s_ready;
   assign keep       = cnt_q < LEN_W'(MAX_FRAME_BYTES);
   assign wr_en      = pend_q && !wr_full;
   assign wr_data    = w_q;
   assign desc_valid = state_q == DESC;
   assign desc_len   = desc_valid ? cnt_q : '0;
   assign desc_ovf   = desc_valid && ovf_q;
   assign busy       = state_q != IDLE;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         sh_q    <= '0;
         w_q     <= '0;
         lane_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         if (wr_en) pend_q <= 1'b0;
         if (acc) begin
            if (keep) begin
               cnt_q  <= cnt_q + 1'b1;
               lane_q <= lane_q + 1'b1;
               if (lane_q == 2'd3 || s_last) begin
                  w_q    <= sh_d;
                  pend_q <= 1'b1;
                  sh_q   <= '0;
               end else sh_q <= sh_d;
            end else ovf_q <= 1'b1;
            state_q <= s_last ? FLUSH : PACK;
         end
         if (state_q == FLUSH && !(pend_q && wr_full)) state_q <= DESC;
         if (desc_valid && desc_ready) begin
            state_q <= IDLE;
            sh_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
         end
      end
   end
endmodule

// File: doc/rx_word_packer.md
Name: rx_word_packer

Overview:
- Upstream neighbour of the Rx output buffer in the VLC receive path.
- Accepts the decoded byte stream from the demodulator/decoder and packs it little-endian into 32-bit words.
- Writes the words into the output buffer's word write port, then emits one frame descriptor per frame (byte count, overflow flag) for the buffer's status registers.

Parameters:
- MAX_FRAME_BYTES, 1024, maximum accepted payload bytes per frame; must be a multiple of 4 and at most 65535.
- LEN_W, 16, width of the byte-count field.

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid and s_ready are both high.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of a frame.
- wr_en  out  1  word write strobe to the buffer (single-cycle pulse).
- wr_data  out  32  packed word.
- wr_full  in  1  buffer cannot take a word this cycle.
- desc_valid  out  1  frame descriptor valid.
- desc_ready  in  1  descriptor consumed.
- desc_len  out  LEN_W  number of bytes stored for the frame.
- desc_ovf  out  1  frame exceeded MAX_FRAME_BYTES; the excess was dropped.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the byte lane index, length counter and shift register are cleared.
- Registers: shift register sh[31:0], lane index lane[1:0], byte counter cnt[LEN_W-1:0], ovf flag.
- Packing: an accepted byte is written into sh[8*lane +: 8] and lane increments. Byte 0 of the frame lands in bits [7:0].
- States:
  - IDLE: s_ready=1. The first accepted byte moves to PACK. A byte with s_last in IDLE is a 1-byte frame and goes to FLUSH.
  - PACK:
    - s_ready is 1 unless a word is pending (see below).
    - When lane==3 and a byte is accepted, the full word is pending. wr_en=1 with wr_data = the completed word in the next cycle if wr_full==0; otherwise the word holds in PACK with s_ready=0 until wr_full drops.
    - An accepted byte with s_last goes to FLUSH.
  - FLUSH:
    - If lane!=0, write the partial word once wr_full==0, with unused upper bytes forced to 0.
    - If lane==0, no write occurs. The last word was already written, and there are no empty-word writes.
    - Then go to DESC.
  - DESC: desc_valid=1 with desc_len=cnt and desc_ovf=ovf, both stable while waiting. s_ready=0. On desc_ready, clear cnt, lane and ovf, and return to IDLE.
- Backpressure: wr_en is only asserted in a cycle where wr_full==0. wr_data is stable while a write is pending.
- Latency: the word write occurs 1 cycle after acceptance of its 4th byte when there is no backpressure. desc_valid asserts 1 cycle after the final write, or after FLUSH when no write is needed.
- Counting: cnt increments per accepted byte only while cnt < MAX_FRAME_BYTES.
- Overflow: bytes arriving when cnt == MAX_FRAME_BYTES are accepted but discarded. They set ovf and produce no write. s_last still ends the frame normally, so the frame never hangs. desc_len saturates at MAX_FRAME_BYTES.
- Throughput: one byte per cycle sustained. The only stall is during a pending word write under wr_full, and in FLUSH/DESC.
- Simultaneous events:
  - s_last on the 4th byte of a word: the word is written, then FLUSH performs no extra write.
  - desc_ready already high on entry to DESC: one cycle in DESC, then IDLE. The next frame's first byte is accepted the cycle after that.
- Reset mid-frame: the partial frame is discarded with no descriptor. Outputs return to reset values on the next edge.

Decomposition:
- Shared receive-path package holds:
  - the state enum (IDLE, PACK, FLUSH, DESC);
  - WORD_W=32 and BYTE_W=8;
  - the descriptor struct {len, ovf}, reused by the output buffer's status logic.
- No sub-module is needed. All logic, including the lane-insert mux, is one module.

Test Plan:
- 8-byte frame 0x01..0x08, no backpressure -> writes 0x04030201 and 0x08070605; desc_len=8, desc_ovf=0.
- 5-byte frame 0xAA,0xBB,0xCC,0xDD,0xEE -> writes 0xDDCCBBAA and 0x000000EE; desc_len=5.
- 4-byte frame with wr_full held high 6 cycles after the 4th byte -> s_ready stays 0 and wr_data stays stable. Exactly one wr_en, in the first cycle wr_full==0.
- MAX_FRAME_BYTES=8, 11-byte frame -> 2 writes only; desc_len=8, desc_ovf=1; the next frame starts with ovf=0.
- desc_ready held low 10 cycles, then a new frame offered -> s_ready=0 throughout DESC; the first byte is accepted only after the handshake.
- ARESET asserted after byte 3 of a frame -> no write and no descriptor; all outputs are 0. The following 4-byte frame 0x11223344 (bytes 0x44,0x33,0x22,0x11) writes 0x11223344.
